// File: rtl/cla_sub_stream.sv
// cla_sub_stream: chunked A - B - borrow_init with a lookahead core per chunk; optional overflow via CLA_SUB_STREAM_OVF_EN
module cla_sub_stream #(
  parameter int BITS = 8
) (
  input  logic            _clk_in,
  input  logic            _rst_in,
  input  logic [BITS-1:0] _a_in,
  input  logic [BITS-1:0] _b_in,
  input  logic            _b_init_in,
  input  logic            _valid_in,
  input  logic            _last_in,
  output logic            _ready_out,
  output logic [BITS-1:0] _d_out,
  output logic            _valid_out,
  output logic            _last_out,
  input  logic            _ready_in,
  output logic            _borrow_out,
  output logic            _zero_out
`ifdef CLA_SUB_STREAM_OVF_EN
  ,
  output logic            _ovf_out
`endif
);
  typedef enum logic {IDLE, MID} state_t;
  state_t state_q;
  logic [BITS-1:0] d_q, sum, g, p, gg, pp;
  logic [BITS:0] c;
  logic valid_q, last_q, borrow_q, zacc_q, zero_q, bin, borrow_d, zacc_d, acc;
`ifdef CLA_SUB_STREAM_OVF_EN
  logic ovf_q;
  assign _ovf_out = ovf_q;
`endif
  assign _ready_out = !valid_q || _ready_in;
  assign acc = _valid_in && _ready_out;
  assign bin = state_q == IDLE ? _b_init_in : borrow_q;
  assign g = _a_in & ~_b_in;
  assign p = _a_in ^ ~_b_in;
  // Kogge-Stone prefix over (g,p), then every carry folds in the inverted borrow
  always_comb begin
    gg = g;
    pp = p;
    c = '0;
    for (int l = 1; l < BITS; l = l * 2)
      for (int k = BITS - 1; k >= l; k--) begin
        gg[k] = gg[k] | (pp[k] & gg[k - l]);
        pp[k] = pp[k] & pp[k - l];
      end
    c[0] = !bin;
    for (int k = 0; k < BITS; k++) c[k + 1] = gg[k] | (pp[k] & !bin);
  end
  assign sum = p ^ c[BITS-1:0];
  assign borrow_d = !c[BITS];
  assign zacc_d = (state_q == IDLE || zacc_q) && sum == '0;
  // Output register stage plus inter-chunk borrow/zero state
  always_ff @(posedge _clk_in or posedge _rst_in) begin
    if (_rst_in) begin
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      d_q      <= '0;
      borrow_q <= 1'b0;
      zero_q   <= 1'b0;
      zacc_q   <= 1'b1;
      state_q  <= IDLE;
`ifdef CLA_SUB_STREAM_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else if (acc) begin
      valid_q  <= 1'b1;
      last_q   <= _last_in;
      d_q      <= sum;
      borrow_q <= borrow_d;
      zacc_q   <= zacc_d;
      zero_q   <= zacc_d;
      state_q  <= _last_in ? IDLE : MID;
`ifdef CLA_SUB_STREAM_OVF_EN
      ovf_q    <= (_a_in[BITS-1] != _b_in[BITS-1]) && (sum[BITS-1] != _a_in[BITS-1]);
`endif
    end else if (_ready_in) begin
      valid_q  <= 1'b0;
    end
  end
  assign _valid_out = valid_q;
  assign _last_out = last_q;
  assign _d_out = d_q;
  assign _borrow_out = borrow_q;
  assign _zero_out = zero_q;
endmodule

// File: tb/tb_cla_sub_stream.sv
// tb_cla_sub_stream: random and directed streams against a whole-operand subtraction model
module tb_cla_sub_stream;
  typedef struct packed {logic [7:0] a, b; logic bi, last;} in_t;
  typedef struct packed {logic [7:0] d; logic last, bor, zero, ovf;} out_t;
  logic clk = 1'b0, rst = 1'b1, vi = 1'b0, ri = 1'b1, li = 1'b0, bii = 1'b0;
  logic [7:0] a_s = '0, b_s = '0, d;
  logic ro, vo, lo, bor, zero, ovf;
  in_t inq[$];
  out_t expq[$];
  int checks = 0, errors = 0;
  cla_sub_stream #(.BITS(8)) dut (
    ._clk_in(clk), ._rst_in(rst), ._a_in(a_s), ._b_in(b_s), ._b_init_in(bii),
    ._valid_in(vi), ._last_in(li), ._ready_out(ro), ._d_out(d), ._valid_out(vo),
    ._last_out(lo), ._ready_in(ri), ._borrow_out(bor), ._zero_out(zero)
`ifdef CLA_SUB_STREAM_OVF_EN
    , ._ovf_out(ovf)
`endif
  );
`ifndef CLA_SUB_STREAM_OVF_EN
  assign ovf = 1'b0;
`endif
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic add_op(input logic [31:0] a, input logic [31:0] b, input logic bi, input int n);
    logic [63:0] m, r;
    in_t s;
    out_t e;
    int w;
    w = 8 * n;
    m = (64'd1 << w) - 64'd1;
    r = ({32'd0, a} & m) - ({32'd0, b} & m) - {63'd0, bi};
    for (int k = 0; k < n; k++) begin
      s.a = a[8*k +: 8];
      s.b = b[8*k +: 8];
      s.bi = k == 0 ? bi : 1'($urandom);
      s.last = k == n - 1;
      inq.push_back(s);
      e.d = r[8*k +: 8];
      e.last = k == n - 1;
      e.bor = r[63];
      e.zero = (r & m) == 64'd0;
      e.ovf = (a[w-1] != b[w-1]) && (r[w-1] != a[w-1]);
      expq.push_back(e);
    end
  endtask
  task automatic drive(input in_t s);
    a_s = s.a;
    b_s = s.b;
    bii = s.bi;
    li = s.last;
  endtask
  task automatic run(input int pv, input int pr);
    int cyc;
    out_t e;
    cyc = 0;
    while ((inq.size() > 0 || expq.size() > 0) && cyc < 5000) begin
      @(posedge clk); #1;
      cyc++;
      ri = $urandom_range(99) < pr;
      vi = inq.size() > 0 && $urandom_range(99) < pv;
      if (vi) drive(inq[0]);
      else drive(in_t'($urandom));
      #1;
      if (vo && ri) begin
        if (expq.size() == 0) chk("extra_out", 1, 0);
        else begin
          e = expq.pop_front();
          chk("d", d, e.d);
          chk("last", lo, e.last);
          if (e.last) begin
            chk("borrow", bor, e.bor);
            chk("zero", zero, e.zero);
`ifdef CLA_SUB_STREAM_OVF_EN
            chk("ovf", ovf, e.ovf);
`endif
          end
        end
      end
      if (vi && ro) void'(inq.pop_front());
    end
    chk("drained", inq.size() + expq.size(), 0);
    vi = 1'b0;
    ri = 1'b1;
  endtask
  initial begin
    logic [31:0] a, b;
    #12;
    chk("rst_valid", vo, 0);
    chk("rst_d", d, 0);
    chk("rst_last", lo, 0);
    chk("rst_borrow", bor, 0);
    chk("rst_zero", zero, 0);
    chk("rst_ready", ro, 1);
    rst = 1'b0;
    add_op(32'h0100, 32'h0001, 1'b0, 2);
    add_op(32'h0000, 32'h0001, 1'b0, 2);
    add_op(32'h1234, 32'h1234, 1'b0, 2);
    add_op(32'h1234, 32'h1234, 1'b1, 2);
    add_op(32'h80, 32'h01, 1'b0, 1);
    add_op(32'h7F, 32'h01, 1'b0, 1);
    run(100, 100);
    add_op(32'hAABB, 32'h1122, 1'b0, 2);
    add_op(32'h00FF0000, 32'h00FF0001, 1'b1, 3);
    @(posedge clk); #1;
    ri = 1'b0;
    vi = 1'b1;
    drive(inq[0]);
    #1;
    chk("bp_first_ready", ro, 1);
    void'(inq.pop_front());
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      drive(inq[0]);
      #1;
      chk("bp_ready", ro, 0);
      chk("bp_valid", vo, 1);
      chk("bp_hold_d", d, expq[0].d);
    end
    run(100, 100);
    add_op(32'h112233, 32'h332211, 1'b1, 3);
    @(posedge clk); #1;
    vi = 1'b1;
    drive(inq[0]);
    @(posedge clk); #1;
    vi = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", vo, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    inq.delete();
    expq.delete();
    add_op(32'h05, 32'h03, 1'b0, 1);
    run(100, 100);
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      b = $urandom_range(3) == 0 ? a : $urandom_range(3) == 0 ? a + 1 : $urandom;
      add_op(a, b, 1'($urandom), $urandom_range(4, 1));
    end
    run(70, 70);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
